fetch_decode_ports: RTL and testbench
=====================================

Name: fetch_decode_ports

Overview:
- CPU front-end block made of three parts: instruction fetch, instruction decode and the I/O port file.
- Fetch holds a word-addressed instruction memory and registers the instruction at `pointer` on each clock.
- Decode splits that instruction into opcode, register and immediate fields, combinationally.
- The port file is a small bank of word registers serving the CPU IN/OUT opcodes.
- Sits between the cpu top (which owns `pointer`, `reg_stack` and the execute logic) and the outside world.

Parameters:
- WORD_WIDTH, 16, instruction, data and port-value width.
- BYTE_WIDTH, 8, width of the bigval immediate.
- NIB_WIDTH, 4, width of the opcode, register and smallval fields.
- IMEM_DEPTH, 256, instruction words (power of two).
- PORT_COUNT, 16, number of port registers (power of two).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- pointer  in  WORD_WIDTH  instruction word address.
- imem_we  in  1  instruction-memory write enable (program load).
- imem_waddr  in  WORD_WIDTH  instruction-memory write address.
- imem_wdata  in  WORD_WIDTH  instruction-memory write data.
- instr  out  WORD_WIDTH  fetched instruction.
- opcode  out  NIB_WIDTH  instr[15:12].
- isaluop  out  1  high when opcode[3]=1.
- aluop  out  3  opcode[2:0].
- reg1  out  NIB_WIDTH  instr[11:8].
- reg2  out  NIB_WIDTH  instr[7:4].
- reg3  out  NIB_WIDTH  instr[3:0].
- bigval  out  BYTE_WIDTH  instr[7:0].
- smallval  out  NIB_WIDTH  instr[3:0].
- portaddr  in  WORD_WIDTH  port address.
- portval  in  WORD_WIDTH  port write data.
- portget  in  1  port read strobe.
- portset  in  1  port write strobe.
- portout  out  WORD_WIDTH  port read data.

Behaviour:
- Reset (rst_n=0, asynchronous): instr=0 (decodes as NOP), all port registers=0, portout=0. Instruction memory contents are not reset.
- Fetch:
  - Rising edge: instr <= imem[pointer mod IMEM_DEPTH]. Latency is one cycle.
  - Address bits above log2(IMEM_DEPTH) are ignored, so addresses wrap.
- Program load:
  - Rising edge with imem_we=1: imem[imem_waddr mod IMEM_DEPTH] <= imem_wdata.
  - Write to the address being fetched in the same cycle: instr gets the old word (read-before-write).
- Decode:
  - Purely combinational from instr; field slices exactly as listed under Ports.
  - Outputs change in the same cycle instr changes.
- Opcode map:
  - 0 NOP, 1 LOAD, 2 STORE, 3 LOADIMM, 4 IN, 5 OUT, 6 JMP, 7 BR.
  - 8..15 are ALU ops: isaluop=1, aluop=0..7.
- Port write: rising edge with portset=1: port[portaddr mod PORT_COUNT] <= portval.
- Port read:
  - Rising edge with portget=1: portout <= port[portaddr mod PORT_COUNT].
  - Otherwise portout holds its value.
  - Read latency is one cycle.
- Simultaneous portget and portset to the same address: portout returns the old value; the register takes the new one.
- Reset during a read or write: the operation is dropped and reset values apply immediately.
- Program load and port access are independent and may occur in the same cycle.

Decomposition:
- Shared package `cpu_pkg`:
  - WORD_WIDTH, BYTE_WIDTH, NIB_WIDTH.
  - OP_NOP..OP_BR opcode constants.
  - Instruction field bit positions.
- One sub-module, `instr_decode`: combinational field decoder.
- Fetch memory and port file are implemented inline in fetch_decode_ports.

Test Plan:
- Reset, then pointer=0 with memory unloaded: instr=0 and opcode=0 after one edge; portout=0; every port reads 0.
- Load imem[5]=16'h3A7C, set pointer=5, one edge: opcode=3, reg1=A, reg2=7, reg3=C, bigval=8'h7C, smallval=C, isaluop=0.
- Load imem[2]=16'hB123, fetch it: isaluop=1, aluop=3. Pointer=16'h0102 with imem[2]=16'h4000 (IMEM_DEPTH 256): instr=16'h4000, showing wrap.
- portset with portaddr=3, portval=16'hBEEF; next cycle portget at portaddr=3: portout=16'hBEEF after one edge. portget at portaddr=19 also returns 16'hBEEF (wrap).
- portget and portset together at address 3 with portval=16'h1234: portout=16'hBEEF; a following read returns 16'h1234.
- rst_n low mid-sequence, asynchronous to the clock: instr and portout go to 0 immediately; port 3 reads 0 afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data widths, opcode encodings and instruction field positions.
package cpu_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int BYTE_WIDTH = 8;
    localparam int NIB_WIDTH  = 4;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_LOAD    = 4'd1;
    localparam logic [3:0] OP_STORE   = 4'd2;
    localparam logic [3:0] OP_LOADIMM = 4'd3;
    localparam logic [3:0] OP_IN      = 4'd4;
    localparam logic [3:0] OP_OUT     = 4'd5;
    localparam logic [3:0] OP_JMP     = 4'd6;
    localparam logic [3:0] OP_BR      = 4'd7;

    // Instruction layout: [15:12] opcode, [11:8] reg1, [7:4] reg2, [3:0] reg3/smallval.
    localparam int OPCODE_LSB = 12;
    localparam int REG1_LSB   = 8;
    localparam int REG2_LSB   = 4;
    localparam int REG3_LSB   = 0;
    localparam int BIGVAL_LSB = 0;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction field decoder; every output is a plain slice of instr.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] instr,
    output logic [NIB_WIDTH-1:0]  opcode,
    output logic                  isaluop,
    output logic [2:0]            aluop,
    output logic [NIB_WIDTH-1:0]  reg1,
    output logic [NIB_WIDTH-1:0]  reg2,
    output logic [NIB_WIDTH-1:0]  reg3,
    output logic [BYTE_WIDTH-1:0] bigval,
    output logic [NIB_WIDTH-1:0]  smallval
);

    assign opcode   = instr[OPCODE_LSB +: NIB_WIDTH];
    // Opcodes 8..15 form the ALU group; the low three bits select the ALU function.
    assign isaluop  = opcode[NIB_WIDTH-1];
    assign aluop    = opcode[2:0];
    assign reg1     = instr[REG1_LSB +: NIB_WIDTH];
    assign reg2     = instr[REG2_LSB +: NIB_WIDTH];
    assign reg3     = instr[REG3_LSB +: NIB_WIDTH];
    assign bigval   = instr[BIGVAL_LSB +: BYTE_WIDTH];
    assign smallval = instr[REG3_LSB +: NIB_WIDTH];

endmodule

// File: rtl/fetch_decode_ports.sv
// CPU front end: instruction memory with registered fetch, field decode, and the IN/OUT port file.
module fetch_decode_ports
    import cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int PORT_COUNT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] pointer,
    input  logic                  imem_we,
    input  logic [WORD_WIDTH-1:0] imem_waddr,
    input  logic [WORD_WIDTH-1:0] imem_wdata,
    output logic [WORD_WIDTH-1:0] instr,
    output logic [NIB_WIDTH-1:0]  opcode,
    output logic                  isaluop,
    output logic [2:0]            aluop,
    output logic [NIB_WIDTH-1:0]  reg1,
    output logic [NIB_WIDTH-1:0]  reg2,
    output logic [NIB_WIDTH-1:0]  reg3,
    output logic [BYTE_WIDTH-1:0] bigval,
    output logic [NIB_WIDTH-1:0]  smallval,
    input  logic [WORD_WIDTH-1:0] portaddr,
    input  logic [WORD_WIDTH-1:0] portval,
    input  logic                  portget,
    input  logic                  portset,
    output logic [WORD_WIDTH-1:0] portout
);

    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int PORT_AW = $clog2(PORT_COUNT);

    logic [WORD_WIDTH-1:0] imem_r [IMEM_DEPTH];
    logic [WORD_WIDTH-1:0] port_r [PORT_COUNT];
    logic [WORD_WIDTH-1:0] instr_r;
    logic [WORD_WIDTH-1:0] portout_r;
    logic [IMEM_AW-1:0]    fetch_idx_s;
    logic [IMEM_AW-1:0]    load_idx_s;
    logic [PORT_AW-1:0]    port_idx_s;
    logic                  unused_addr_bits_s;

    // Addresses wrap: only the low bits select a word.
    assign fetch_idx_s = pointer[IMEM_AW-1:0];
    assign load_idx_s  = imem_waddr[IMEM_AW-1:0];
    assign port_idx_s  = portaddr[PORT_AW-1:0];
    assign unused_addr_bits_s = ^{pointer[WORD_WIDTH-1:IMEM_AW],
                                  imem_waddr[WORD_WIDTH-1:IMEM_AW],
                                  portaddr[WORD_WIDTH-1:PORT_AW]};

    // Program load; memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_r[load_idx_s] <= imem_wdata;
        end
    end

    // Registered fetch; a same-cycle load to this address is seen next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= {WORD_WIDTH{1'b0}};
        end else begin
            instr_r <= imem_r[fetch_idx_s];
        end
    end

    // Port register bank written by OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PORT_COUNT; i++) begin
                port_r[i] <= {WORD_WIDTH{1'b0}};
            end
        end else if (portset) begin
            port_r[port_idx_s] <= portval;
        end
    end

    // Port read data for IN; holds between strobes and returns the pre-write value on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            portout_r <= {WORD_WIDTH{1'b0}};
        end else if (portget) begin
            portout_r <= port_r[port_idx_s];
        end
    end

    assign instr   = instr_r;
    assign portout = portout_r;

    instr_decode u_instr_decode (
        .instr    (instr_r),
        .opcode   (opcode),
        .isaluop  (isaluop),
        .aluop    (aluop),
        .reg1     (reg1),
        .reg2     (reg2),
        .reg3     (reg3),
        .bigval   (bigval),
        .smallval (smallval)
    );

endmodule

// File: tb/tb_fetch_decode_ports.sv
// Directed self-checking bench for fetch_decode_ports with hand-computed expectations.
module tb_fetch_decode_ports;

    logic        clk;
    logic        rst_n;
    logic [15:0] pointer;
    logic        imem_we;
    logic [15:0] imem_waddr;
    logic [15:0] imem_wdata;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        isaluop;
    logic [2:0]  aluop;
    logic [3:0]  reg1;
    logic [3:0]  reg2;
    logic [3:0]  reg3;
    logic [7:0]  bigval;
    logic [3:0]  smallval;
    logic [15:0] portaddr;
    logic [15:0] portval;
    logic        portget;
    logic        portset;
    logic [15:0] portout;

    int checks_cnt;
    int failures_cnt;

    fetch_decode_ports dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pointer    (pointer),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .instr      (instr),
        .opcode     (opcode),
        .isaluop    (isaluop),
        .aluop      (aluop),
        .reg1       (reg1),
        .reg2       (reg2),
        .reg3       (reg3),
        .bigval     (bigval),
        .smallval   (smallval),
        .portaddr   (portaddr),
        .portval    (portval),
        .portget    (portget),
        .portset    (portset),
        .portout    (portout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [15:0] addr, input logic [15:0] data);
        imem_we    = 1'b1;
        imem_waddr = addr;
        imem_wdata = data;
        step();
        imem_we    = 1'b0;
    endtask

    initial begin
        checks_cnt   = 0;
        failures_cnt = 0;
        rst_n      = 1'b0;
        pointer    = 16'h0000;
        imem_we    = 1'b0;
        imem_waddr = 16'h0000;
        imem_wdata = 16'h0000;
        portaddr   = 16'h0000;
        portval    = 16'h0000;
        portget    = 1'b0;
        portset    = 1'b0;

        #12;
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_portout", portout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        load(16'h0000, 16'h0000);
        pointer = 16'h0000;
        step();
        check_eq("nop_instr", instr, 32'h0);
        check_eq("nop_opcode", opcode, 32'h0);
        check_eq("idle_portout", portout, 32'h0);

        portget = 1'b1;
        for (int i = 0; i < 16; i++) begin
            portaddr = 16'(i);
            step();
            check_eq($sformatf("port%0d_reset", i), portout, 32'h0);
        end
        portget = 1'b0;

        load(16'h0005, 16'h3A7C);
        pointer = 16'h0005;
        step();
        check_eq("f5_instr", instr, 32'h3A7C);
        check_eq("f5_opcode", opcode, 32'h3);
        check_eq("f5_reg1", reg1, 32'hA);
        check_eq("f5_reg2", reg2, 32'h7);
        check_eq("f5_reg3", reg3, 32'hC);
        check_eq("f5_bigval", bigval, 32'h7C);
        check_eq("f5_smallval", smallval, 32'hC);
        check_eq("f5_isaluop", isaluop, 32'h0);

        load(16'h0002, 16'hB123);
        pointer = 16'h0002;
        step();
        check_eq("alu_opcode", opcode, 32'hB);
        check_eq("alu_isaluop", isaluop, 32'h1);
        check_eq("alu_aluop", aluop, 32'h3);

        load(16'h0002, 16'h4000);
        pointer = 16'h0102;
        step();
        check_eq("wrap_instr", instr, 32'h4000);
        check_eq("wrap_opcode", opcode, 32'h4);

        // Load wraps too: address 0x0109 lands in word 9.
        load(16'h0109, 16'h1111);
        pointer = 16'h0009;
        step();
        check_eq("wrap_load", instr, 32'h1111);

        load(16'h0007, 16'hAAAA);
        pointer    = 16'h0007;
        imem_we    = 1'b1;
        imem_waddr = 16'h0007;
        imem_wdata = 16'h5555;
        step();
        imem_we = 1'b0;
        check_eq("rbw_old", instr, 32'hAAAA);
        step();
        check_eq("rbw_new", instr, 32'h5555);

        portset  = 1'b1;
        portaddr = 16'h0003;
        portval  = 16'hBEEF;
        step();
        portset = 1'b0;
        check_eq("set_no_read", portout, 32'h0);
        portget = 1'b1;
        step();
        check_eq("port3_read", portout, 32'hBEEF);
        portaddr = 16'h0013;
        step();
        check_eq("port19_wrap", portout, 32'hBEEF);
        portget  = 1'b0;
        portaddr = 16'h0004;
        step();
        check_eq("portout_hold", portout, 32'hBEEF);

        portget  = 1'b1;
        portset  = 1'b1;
        portaddr = 16'h0003;
        portval  = 16'h1234;
        step();
        portset = 1'b0;
        check_eq("collide_old", portout, 32'hBEEF);
        step();
        check_eq("collide_new", portout, 32'h1234);
        portget = 1'b0;

        pointer = 16'h0005;
        step();
        check_eq("pre_rst_instr", instr, 32'h3A7C);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_instr", instr, 32'h0);
        check_eq("async_opcode", opcode, 32'h0);
        check_eq("async_portout", portout, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        portget  = 1'b1;
        portaddr = 16'h0003;
        step();
        portget = 1'b0;
        check_eq("port3_after_rst", portout, 32'h0);
        check_eq("imem_kept", instr, 32'h3A7C);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
